hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_ctrl_div_seq.sv | 93 +++++++++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: divider sequencer states and
// forward-select codes.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        if (hit_m) begin
            fwd_sel = FWD_MEM;
        end else if (hit_w) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end
    endfunction

endpackage

// File: rtl/hazard_ctrl_div_seq.sv
// Divider launch/busy sequencer with timeout counter.
// Present only when HAZARD_CTRL_DIV_EN is defined; otherwise outputs tie to 0.
module div_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic div_reqE,
    input  logic div_ready,
    input  logic mem_stall,
    input  logic flush_now,
    output logic divstall,
    output logic div_start,
    output logic div_abort,
    output logic div_err
);

`ifdef HAZARD_CTRL_DIV_EN
    localparam logic [5:0] TMO_LAST = 6'(DIV_TIMEOUT - 1);

    div_state_e state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        divstall  = 1'b0;
        div_start = 1'b0;
        div_abort = 1'b0;
        if (state_q != IDLE && flush_now) begin
            state_d   = IDLE;
            cnt_d     = '0;
            div_abort = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (div_reqE && !flush_now && !mem_stall) begin
                        state_d = START;
                    end
                end
                START: begin
                    divstall  = 1'b1;
                    div_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
                BUSY: begin
                    divstall = 1'b1;
                    if (div_ready) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                // E advances here; returning to IDLE blocks a relaunch of the same op
                DONE: state_d = IDLE;
            endcase
        end
    end

    assign div_err = err_q;
`else
    logic unused_div;
    assign unused_div = ^{clk, rst, div_reqE, div_ready, mem_stall,
                          flush_now, 6'(DIV_TIMEOUT)};
    assign divstall  = 1'b0;
    assign div_start = 1'b0;
    assign div_abort = 1'b0;
    assign div_err   = 1'b0;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stalls, flushes, forwarding and divider handshake.
// Divider support is built only with HAZARD_CTRL_DIV_EN defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int DIV_TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic [1:0]       memtoregE,
    input  logic [1:0]       memtoregM,
    input  logic             branchD,
    input  logic             jumpregD,
    input  logic             div_reqE,
    input  logic             div_ready,
    input  logic             mem_stall,
    input  logic             exc_flush,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             forwardaD,
    output logic             forwardbD,
    output logic             div_start,
    output logic             div_abort,
    output logic             div_err
);

    logic flush_pend_q, flush_pend_d;
    logic flush_now;
    logic divstall, lwstall, brstall;
    logic rs_nz, rt_nz, br_x, br_y;

    // A flush seen under a memory stall is parked until memory is ready
    assign flush_now = rst && (exc_flush || flush_pend_q) && !mem_stall;

    always_comb begin
        flush_pend_d = flush_pend_q || (exc_flush && mem_stall);
        if (flush_now) begin
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end

    assign forwardaE = fwd_sel(
        rsE != '0 && regwriteM && rsE == writeregM,
        rsE != '0 && regwriteW && rsE == writeregW);
    assign forwardbE = fwd_sel(
        rtE != '0 && regwriteM && rtE == writeregM,
        rtE != '0 && regwriteW && rtE == writeregW);
    assign forwardaD = rsD != '0 && regwriteM && rsD == writeregM;
    assign forwardbD = rtD != '0 && regwriteM && rtD == writeregM;

    assign rs_nz   = rsD != '0;
    assign rt_nz   = rtD != '0;
    assign lwstall = memtoregE != 2'b00 && (rtE == rsD || rtE == rtD);
    assign br_x    = regwriteE &&
                     ((rs_nz && writeregE == rsD) || (rt_nz && writeregE == rtD));
    assign br_y    = memtoregM != 2'b00 &&
                     ((rs_nz && writeregM == rsD) || (rt_nz && writeregM == rtD));
    assign brstall = (branchD || jumpregD) && (br_x || br_y);

    div_seq #(
        .DIV_TIMEOUT(DIV_TIMEOUT)
    ) u_div_seq (
        .clk      (clk),
        .rst      (rst),
        .div_reqE (div_reqE),
        .div_ready(div_ready),
        .mem_stall(mem_stall),
        .flush_now(flush_now),
        .divstall (divstall),
        .div_start(div_start),
        .div_abort(div_abort),
        .div_err  (div_err)
    );

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (rst) begin
            if (flush_now) begin
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
            end else if (mem_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
            end else if (divstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (lwstall || brstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vectors, multi-cycle sequences and a
// randomized run against a cycle-level reference model.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam int TMO = 63;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW;
    logic [1:0] memtoregE, memtoregM;
    logic       branchD, jumpregD, div_reqE, div_ready, mem_stall, exc_flush;
    logic       stallF, stallD, stallE, stallM, flushD, flushE, flushM;
    logic [1:0] forwardaE, forwardbE;
    logic       forwardaD, forwardbD, div_start, div_abort, div_err;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit m_pend, m_act, m_done, m_err;
    int m_t;
    logic [15:0] last_got;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .DIV_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jumpregD(jumpregD),
        .div_reqE(div_reqE), .div_ready(div_ready),
        .mem_stall(mem_stall), .exc_flush(exc_flush),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .div_start(div_start), .div_abort(div_abort), .div_err(div_err)
    );

    typedef struct packed {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW;
        logic [1:0] mtE, mtM;
        logic       brD, jrD, mem, exc;
        logic [3:0] x_st;
        logic [2:0] x_fl;
        logic [1:0] x_fa, x_fb;
        logic       x_fad, x_fbd;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic clr();
        rst = 1'b1;
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW} = '0;
        memtoregE = 2'b00;
        memtoregM = 2'b00;
        {branchD, jumpregD, div_reqE, div_ready, mem_stall, exc_flush} = '0;
    endtask

    function automatic logic [1:0] fwd_e(input logic [4:0] r);
        if (r != 0 && regwriteM && r == writeregM) return 2'b10;
        if (r != 0 && regwriteW && r == writeregW) return 2'b01;
        return 2'b00;
    endfunction

    // One clock: compare at negedge, advance model, return just after posedge
    task automatic step(input string tag);
        logic fnow, lw, br, hx, hy;
        logic [3:0] st;
        logic [2:0] fl;
        logic [15:0] exp, got;
        @(negedge clk);
        if (!rst) begin
            m_pend = 0; m_act = 0; m_done = 0; m_err = 0; m_t = 0;
        end
        fnow = rst && (exc_flush || m_pend) && !mem_stall;
        lw = memtoregE != 0 && (rtE == rsD || rtE == rtD);
        hx = regwriteE && ((rsD != 0 && writeregE == rsD) ||
                           (rtD != 0 && writeregE == rtD));
        hy = memtoregM != 0 && ((rsD != 0 && writeregM == rsD) ||
                                (rtD != 0 && writeregM == rtD));
        br = (branchD || jumpregD) && (hx || hy);
        st = 4'b0000;
        fl = 3'b000;
        if (!rst) begin
            st = 4'b0000;
        end else if (fnow) begin
            fl = 3'b111;
        end else if (mem_stall) begin
            st = 4'b1111;
        end else if (DIV_ON && m_act) begin
            st = 4'b1110; fl = 3'b001;
        end else if (lw || br) begin
            st = 4'b1100; fl = 3'b010;
        end
        exp = {st, fl, fwd_e(rsE), fwd_e(rtE),
               logic'(rsD != 0 && regwriteM && rsD == writeregM),
               logic'(rtD != 0 && regwriteM && rtD == writeregM),
               logic'(DIV_ON && rst && m_act && m_t == 0 && !fnow),
               logic'(DIV_ON && fnow && (m_act || m_done)),
               logic'(DIV_ON && m_err)};
        got = {stallF, stallD, stallE, stallM, flushD, flushE, flushM,
               forwardaE, forwardbE, forwardaD, forwardbD,
               div_start, div_abort, div_err};
        last_got = got;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
        if (rst) begin
            if (fnow) m_pend = 0;
            else if (exc_flush && mem_stall) m_pend = 1;
            if (DIV_ON) begin
                if (fnow) begin
                    m_act = 0; m_done = 0;
                end else if (m_act) begin
                    if (m_t == 0) m_t = 1;
                    else if (div_ready) begin m_act = 0; m_done = 1; end
                    else if (m_t == TMO) begin m_err = 1; m_act = 0; m_done = 1; end
                    else m_t++;
                end else if (m_done) begin
                    m_done = 0;
                end else if (div_reqE && !mem_stall) begin
                    m_act = 1; m_t = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step("reset");
        rst = 1'b1;
    endtask

    initial begin
        vec_t v;
        int cnt, first, nst, nstart, nflm, ab, e65;

        // directed combinational vectors
        v = '0; v.mtE = 2'b01; v.rtE = 8; v.rsD = 8;
        v.x_st = 4'b1100; v.x_fl = 3'b010; vq.push_back(v);
        v = '0; v.rsE = 5; v.wM = 5; v.wW = 5; v.rwM = 1; v.rwW = 1;
        v.x_fa = 2'b10; vq.push_back(v);
        v.rsE = 0; v.x_fa = 2'b00; vq.push_back(v);
        v = '0; v.rsE = 3; v.rtE = 7; v.wM = 3; v.rwM = 1; v.wW = 7; v.rwW = 1;
        v.x_fa = 2'b10; v.x_fb = 2'b01; vq.push_back(v);
        v = '0; v.rsD = 4; v.rtD = 4; v.wM = 4; v.rwM = 1;
        v.x_fad = 1; v.x_fbd = 1; vq.push_back(v);
        v = '0; v.brD = 1; v.rsD = 6; v.wE = 6; v.rwE = 1;
        v.x_st = 4'b1100; v.x_fl = 3'b010; vq.push_back(v);
        v = '0; v.jrD = 1; v.rtD = 9; v.wM = 9; v.mtM = 2'b10;
        v.x_st = 4'b1100; v.x_fl = 3'b010; vq.push_back(v);
        v = '0; v.brD = 1; v.rwE = 1; vq.push_back(v);
        v = '0; v.brD = 1; v.rsD = 6; v.wE = 6; vq.push_back(v);
        v = '0; v.mtE = 2'b11; v.rtE = 2; v.rtD = 2; v.rsD = 1;
        v.x_st = 4'b1100; v.x_fl = 3'b010; vq.push_back(v);
        v = '0; v.mtE = 2'b01; v.rtE = 8; v.rsD = 8; v.mem = 1;
        v.x_st = 4'b1111; vq.push_back(v);
        v = '0; v.mtE = 2'b01; v.rtE = 8; v.rsD = 8; v.exc = 1;
        v.x_fl = 3'b111; vq.push_back(v);
        v = '0; vq.push_back(v);

        clr();
        rst = 1'b0;
        step("reset0");
        mem_stall = 1'b1;
        exc_flush = 1'b1;
        step("reset1");
        chk("reset_outputs", int'(last_got), 0);
        clr();

        foreach (vq[i]) begin
            v = vq[i];
            rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
            writeregE = v.wE; writeregM = v.wM; writeregW = v.wW;
            regwriteE = v.rwE; regwriteM = v.rwM; regwriteW = v.rwW;
            memtoregE = v.mtE; memtoregM = v.mtM;
            branchD = v.brD; jumpregD = v.jrD;
            mem_stall = v.mem; exc_flush = v.exc;
            step("vec");
            chk($sformatf("vec%0d_stall", i), int'(last_got[15:12]), int'(v.x_st));
            chk($sformatf("vec%0d_flush", i), int'(last_got[11:9]), int'(v.x_fl));
            chk($sformatf("vec%0d_fwdE", i), int'(last_got[8:5]), int'({v.x_fa, v.x_fb}));
            chk($sformatf("vec%0d_fwdD", i), int'(last_got[4:3]), int'({v.x_fad, v.x_fbd}));
        end

        // exception during a 3-cycle memory stall
        clr();
        cnt = 0;
        first = -1;
        for (int i = 0; i < 6; i++) begin
            mem_stall = i < 3;
            exc_flush = i == 0;
            step("memflush");
            if (last_got[11:9] == 3'b111) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        chk("memflush_count", cnt, 1);
        chk("memflush_cycle", first, 3);

        // divide with ready 4 cycles after start
        clr();
        do_reset();
        nst = 0; nstart = 0; nflm = 0;
        for (int i = 0; i < 10; i++) begin
            div_reqE = i <= 6;
            div_ready = i == 5;
            step("div");
            nst += int'(last_got[13]);
            nstart += int'(last_got[2]);
            if (last_got[13] && last_got[9]) nflm++;
        end
        chk("div_stallE_cycles", nst, DIV_ON ? 5 : 0);
        chk("div_start_count", nstart, DIV_ON ? 1 : 0);
        chk("div_flushM_cycles", nflm, DIV_ON ? 5 : 0);

        // abort while busy
        clr();
        ab = 0;
        for (int i = 0; i < 5; i++) begin
            div_reqE = i == 0;
            exc_flush = i == 3;
            step("abort");
            if (i == 3) ab = int'(last_got[1]);
        end
        chk("abort_pulse", ab, DIV_ON ? 1 : 0);
        chk("abort_no_stall_after", int'(last_got[15:12]), 0);

        // timeout: divider never answers
        clr();
        do_reset();
        nst = 0;
        e65 = 0;
        for (int i = 0; i < 70; i++) begin
            div_reqE = i == 0;
            step("timeout");
            nst += int'(last_got[13]);
            if (i == 65) e65 = int'({last_got[13], last_got[0]});
        end
        chk("tmo_stall_cycles", nst, DIV_ON ? 64 : 0);
        chk("tmo_release_err", e65, DIV_ON ? 1 : 0);
        chk("tmo_err_sticky", int'(last_got[0]), DIV_ON ? 1 : 0);
        rst = 1'b0;
        step("tmo_reset");
        chk("tmo_err_cleared", int'(last_got[0]), 0);

        // reset while busy gives no abort
        clr();
        div_reqE = 1'b1;
        step("rstbusy");
        div_reqE = 1'b0;
        step("rstbusy");
        step("rstbusy");
        rst = 1'b0;
        step("rstbusy");
        chk("rst_busy_no_abort", int'(last_got[2:1]), 0);
        rst = 1'b1;
        step("rstbusy");
        chk("rst_busy_idle", int'(last_got[15:12]), 0);

        // randomized run against the model
        clr();
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 149) != 0;
            rsD = 5'($urandom_range(0, 3));
            rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3));
            rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            regwriteE = 1'($urandom);
            regwriteM = 1'($urandom);
            regwriteW = 1'($urandom);
            memtoregE = $urandom_range(0, 2) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            memtoregM = $urandom_range(0, 2) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            branchD = $urandom_range(0, 3) == 0;
            jumpregD = $urandom_range(0, 7) == 0;
            div_reqE = 1'($urandom);
            div_ready = $urandom_range(0, 7) == 0;
            mem_stall = $urandom_range(0, 3) == 0;
            exc_flush = $urandom_range(0, 15) == 0;
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
